sub_seq_ctrl: RTL and testbench
===============================

SUB_SEQ_CTRL -- requirements
Module: sub_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles; the legal range is 1..8.
REQ-002 The block SHALL derive W = 4*NIBBLES; all operand and result widths below are W.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have port a, input, W bits: minuend.
REQ-008 The block SHALL have port b, input, W bits: subtrahend.
REQ-009 The block SHALL have port bin, input, 1 bit: borrow-in to nibble 0.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a result is held on diff, bout and zero.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port diff, output, W bits: a - b - bin, modulo 2^W.
REQ-013 The block SHALL have port bout, output, 1 bit: final borrow-out from the top nibble.
REQ-014 The block SHALL have port zero, output, 1 bit: set when diff == 0.
REQ-015 The block SHALL have port busy, output, 1 bit: set while in the CALC state.

Function
REQ-016 The block SHALL contain exactly one instance of the team's 4-bit ripple-carry subtractor (ports a, b, bin, diff, bout) and SHALL compute every nibble through it; no W-bit subtract operator is permitted.
REQ-017 The block SHALL implement the state machine IDLE -> CALC -> DONE -> IDLE.
REQ-018 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only; busy SHALL be 1 in CALC only.
REQ-019 In IDLE, when in_valid and in_ready are both 1 at a clock edge, the block SHALL capture a, b and bin into internal registers, clear the nibble index to 0, load the borrow register with bin, and enter CALC.
REQ-020 On each CALC cycle, the block SHALL drive the subtractor with nibble[idx] of the captured a, nibble[idx] of the captured b and the borrow register.
REQ-021 On each CALC edge, the block SHALL write the subtractor diff into diff[4*idx+3:4*idx], load its bout into the borrow register, and increment idx.
REQ-022 On the CALC edge where idx == NIBBLES-1, the block SHALL enter DONE.
REQ-023 The block SHALL not increment idx past NIBBLES-1.
REQ-024 Latency SHALL be exactly NIBBLES cycles: out_valid rises NIBBLES clock edges after the accepting edge (4 for the default).
REQ-025 In DONE, bout SHALL equal the borrow register and zero SHALL equal (diff == 0).
REQ-026 In DONE, diff, bout and zero SHALL be held stable until out_ready = 1.
REQ-027 In DONE, out_ready = 1 at an edge SHALL return the block to IDLE; in_ready SHALL rise on the following cycle.
REQ-028 The block SHALL ignore a, b, bin and in_valid outside IDLE.
REQ-029 The block SHALL not accept new operands on the same edge that a result is consumed.
REQ-030 The block SHALL ignore out_ready outside DONE.
REQ-031 diff, bout and zero SHALL retain the last result in IDLE until the next accept; CALC overwrites diff nibble by nibble.
REQ-032 For NIBBLES = 1, CALC SHALL last one cycle.

Reset
REQ-033 While rst_n = 0, the block SHALL immediately force state = IDLE, idx = 0, borrow register = 0, captured operands = 0, diff = 0 and bout = 0.
REQ-034 While rst_n = 0, the outputs SHALL read in_ready = 1, out_valid = 0, busy = 0, zero = 1, diff = 0 and bout = 0.
REQ-035 Reset asserted mid-CALC or mid-DONE SHALL discard the operation with no partial result visible.
REQ-036 After rst_n deasserts, the first accept SHALL occur no earlier than the first rising edge with rst_n = 1.

Verification (NIBBLES = 4)
REQ-037 The bench SHALL cover: a = 0x1234, b = 0x0234, bin = 0 -> diff = 0x1000, bout = 0, zero = 0, with out_valid exactly 4 edges after the accept.
REQ-038 The bench SHALL cover: a = 0x0006, b = 0x0008, bin = 0 -> diff = 0xFFFE, bout = 1, with the borrow propagating through all four nibbles.
REQ-039 The bench SHALL cover: a = 0x5555, b = 0x5555, bin = 0 -> diff = 0x0000, zero = 1, bout = 0; then the same operands with bin = 1 -> diff = 0xFFFF, zero = 0, bout = 1.
REQ-040 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE, with in_valid = 1 and new operands -> outputs unchanged and in_ready = 0; then out_ready = 1 -> IDLE, and the new operands are accepted on the next edge.
REQ-041 The bench SHALL cover: a changed to 0xFFFF during CALC after accepting a = 0x000A, b = 0x0003 -> diff = 0x0007, bout = 0.
REQ-042 The bench SHALL cover: rst_n pulsed low 2 cycles after the accept -> out_valid = 0, busy = 0, in_ray = 1 and diff = 0 immediately; a following operation a = 0x000F, b = 0x0001 -> diff = 0x000E.

Source files
------------

// File: rtl/sub_seq_ctrl.sv
// Nibble-serial W-bit subtractor: one 4-bit ripple subtractor is reused across
// NIBBLES cycles under an IDLE -> CALC -> DONE handshake controller.

module sub4_rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);
    logic [4:0] brw;

    always_comb begin
        brw    = '0;
        diff   = '0;
        brw[0] = bin;
        for (int unsigned i = 0; i < 4; i++) begin
            diff[i]  = a[i] ^ b[i] ^ brw[i];
            brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
        end
    end

    assign bout = brw[4];
endmodule

module sub_seq_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 bin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] diff,
    output logic                 bout,
    output logic                 zero,
    output logic                 busy
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              brw_q, brw_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      diff_q, diff_d;

    logic [3:0]        a_nib, b_nib, sub_diff;
    logic              sub_bout;

    sub4_rca u_sub4 (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (brw_q),
        .diff (sub_diff),
        .bout (sub_bout)
    );

    // Nibble select and write-back are decoded per nibble to keep every slice constant.
    always_comb begin
        a_nib   = '0;
        b_nib   = '0;
        state_d = state_q;
        idx_d   = idx_q;
        brw_d   = brw_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;

        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDXW'(n)) begin
                a_nib = a_q[4*n +: 4];
                b_nib = b_q[4*n +: 4];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int unsigned n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDXW'(n)) begin
                        diff_d[4*n +: 4] = sub_diff;
                    end
                end
                brw_d = sub_bout;
                if (idx_q == IDXW'(NIBBLES - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            brw_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            brw_q   <= brw_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC);
    assign diff      = diff_q;
    assign bout      = brw_q;
    assign zero      = (diff_q == '0);
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed bench for sub_seq_ctrl at NIBBLES = 4: vector table plus
// hand-written handshake, input-change and reset corner sequences.

module tb_sub_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    sub_seq_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] exp_diff;
        logic        exp_bout;
        logic        exp_zero;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accepts one operand set and waits for out_valid; returns edges after the accept.
    task automatic start_and_wait(input logic [15:0] va, input logic [15:0] vb,
                                  input logic vbin, input logic [15:0] junk, output int lat);
        @(negedge clk);
        a = va; b = vb; bin = vbin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = junk; b = junk; bin = ~vbin;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
        check({name, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        start_and_wait(v.a, v.b, v.bin, 16'hA5A5, lat);
        check({name, "_latency"}, 32'(lat), 32'd4);
        check({name, "_diff"}, 32'(diff), 32'(v.exp_diff));
        check({name, "_bout"}, 32'(bout), 32'(v.exp_bout));
        check({name, "_zero"}, 32'(zero), 32'(v.exp_zero));
        check({name, "_busy_done"}, 32'(busy), 32'd0);
        consume(name);
        check({name, "_diff_retained"}, 32'(diff), 32'(v.exp_diff));
    endtask

    vec_t vecs[7];

    initial begin
        int lat;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0006, 16'h0008, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[2] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[3] = '{16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        // Reset state while rst_n is held low
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Result held in DONE while out_ready is low; new operands are ignored.
        start_and_wait(16'h1234, 16'h0234, 1'b0, 16'h0000, lat);
        check("hold_latency", 32'(lat), 32'd4);
        in_valid = 1'b1; a = 16'h0F0F; b = 16'h0101; bin = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("hold%0d_diff", c), 32'(diff), 32'h1000);
            check($sformatf("hold%0d_bout", c), 32'(bout), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_release_in_ready", 32'(in_ready), 32'd1);
        check("hold_release_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("hold_next_accept_busy", 32'(busy), 32'd1);
        in_valid = 1'b0; a = 16'hFFFF; b = 16'h0000;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold_next_latency", 32'(lat), 32'd4);
        check("hold_next_diff", 32'(diff), 32'h0E0E);
        check("hold_next_bout", 32'(bout), 32'd0);
        consume("hold_next");

        // Operand inputs changed during CALC must not affect the result.
        start_and_wait(16'h000A, 16'h0003, 1'b0, 16'hFFFF, lat);
        check("chg_latency", 32'(lat), 32'd4);
        check("chg_diff", 32'(diff), 32'h0007);
        check("chg_bout", 32'(bout), 32'd0);
        consume("chg");

        // Reset pulse two cycles into CALC discards the partial result.
        @(negedge clk);
        a = 16'h1239; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        check("mid_partial_before_rst", 32'(diff[7:0]), 32'h38);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_bout", 32'(bout), 32'd0);
        check("mid_rst_zero", 32'(zero), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_rst", '{16'h000F, 16'h0001, 1'b0, 16'h000E, 1'b0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
